// File: rtl/toggle_pulse_rx_pkg.sv
// Shared constants and types for the toggle-to-pulse receiver.
package toggle_pulse_rx_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 4;

  // Pending-count type for the default counter width.
  typedef logic [CNT_W_DEF-1:0] pend_cnt_t;

  // Largest count a CNT_W-bit pending counter can hold.
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchronizer with asynchronous active-high reset.
// Also usable on the sender side to bring ack_lvl back into its domain.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/toggle_pulse_rx.sv
// Receive end of the pulse-to-level toggle link.
// Each transition on lvl_in becomes one event, buffered in a saturating
// pending counter and drained over a valid/ready handshake.
// Build option: define TOGGLE_PULSE_RX_ACK_EN to return an acknowledge toggle
// per accepted event on ack_lvl; without it ack_lvl is tied low (open-loop).
module toggle_pulse_rx
  import toggle_pulse_rx_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lvl_in,
  output logic             pulse_vld,
  input  logic             pulse_rdy,
  output logic             ack_lvl,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic             lvl_s;
  logic             prev_reg;
  logic             evt;
  logic             fire;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_reg;
  logic             ovf_next;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lvl_sync (
    .clk (clk),
    .rst (rst),
    .d   (lvl_in),
    .q   (lvl_s)
  );

  // Delay the synchronized level one cycle so either transition is visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg <= 1'b0;
    end else begin
      prev_reg <= lvl_s;
    end
  end

  assign evt       = lvl_s ^ prev_reg;
  // Valid comes straight from the registered count, so it never depends on ready.
  assign pulse_vld = (cnt_reg != '0);
  assign fire      = pulse_vld & pulse_rdy;

  // Next count: an arrival and a departure in the same cycle cancel out, so
  // overflow is only possible when an event arrives with nothing leaving.
  always_comb begin
    cnt_next = cnt_reg;
    ovf_next = ovf_reg;
    if (ovf_clr) begin
      ovf_next = 1'b0;
    end
    if (evt && !fire) begin
      if (cnt_reg == CNT_MAX) begin
        ovf_next = 1'b1;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end else if (!evt && fire) begin
      cnt_next = cnt_reg - CNT_W'(1);
    end
  end

  // Register the pending count and the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      ovf_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      ovf_reg <= ovf_next;
    end
  end

  assign pend_cnt = cnt_reg;
  assign ovf      = ovf_reg;

`ifdef TOGGLE_PULSE_RX_ACK_EN
  logic ack_reg;

  // Flip the acknowledge level once per delivered event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_reg <= 1'b0;
    end else if (fire) begin
      ack_reg <= ~ack_reg;
    end
  end

  assign ack_lvl = ack_reg;
`else
  assign ack_lvl = 1'b0;
`endif

endmodule

// File: tb/tb_toggle_pulse_rx.sv
// Self-checking bench for toggle_pulse_rx at default parameters.
module tb_toggle_pulse_rx;

  localparam int S    = 2;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;
`ifdef TOGGLE_PULSE_RX_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          lvl_in = 1'b0;
  logic          pulse_rdy = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          pulse_vld;
  logic          ack_lvl;
  logic          ovf;
  logic [CW-1:0] pend_cnt;

  int vectors = 0;
  int miscompares = 0;

  toggle_pulse_rx #(
    .SYNC_STAGES (S),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lvl_in    (lvl_in),
    .pulse_vld (pulse_vld),
    .pulse_rdy (pulse_rdy),
    .ack_lvl   (ack_lvl),
    .pend_cnt  (pend_cnt),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference model: an event is seen S edges after the edge that first
  // samples a new lvl_in value; the count is arrivals minus departures,
  // with arrivals beyond the maximum discarded.
  logic [7:0]    m_hist = '0;   // m_hist[i] = lvl_in sampled i+1 edges ago
  logic [CW-1:0] m_cnt  = '0;
  logic          m_ovf  = 1'b0;
  logic          m_ack  = 1'b0;
  logic          m_evt;
  logic          m_fire;
  int            m_nc;

  assign m_evt  = m_hist[S-1] ^ m_hist[S];
  assign m_fire = (m_cnt != 0) && pulse_rdy;
  assign m_nc   = int'(m_cnt) + int'(m_evt) - int'(m_fire);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hist <= '0;
      m_cnt  <= '0;
      m_ovf  <= 1'b0;
      m_ack  <= 1'b0;
    end else begin
      m_hist <= {m_hist[6:0], lvl_in};
      m_cnt  <= (m_nc > MAXC) ? m_cnt : CW'(m_nc);
      m_ovf  <= (m_nc > MAXC) ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
      m_ack  <= ACK_EN ? (m_ack ^ m_fire) : 1'b0;
    end
  end

  logic [CW+2:0] dut_obs;
  logic [CW+2:0] exp_obs;
  assign dut_obs = {pulse_vld, ack_lvl, ovf, pend_cnt};
  assign exp_obs = {(m_cnt != 0), m_ack, m_ovf, m_cnt};

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; lvl_in = 1'b0; pulse_rdy = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pulse_rdy = 1'b1;
    repeat (5) begin
      @(negedge clk);
      vectors++;
      if (dut_obs !== '0) begin
        miscompares++;
        $display("FAIL reset_hold: got %b want %b", dut_obs, {(CW+3){1'b0}});
      end
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      vectors++;
      if (dut_obs !== '0) begin
        miscompares++;
        $display("FAIL reset_idle: got %b want %b", dut_obs, {(CW+3){1'b0}});
      end
    end
  endtask

  task automatic test_single();
    int first_vld = 0;
    int vld_cycles = 0;
    int first_ack = 0;
    @(negedge clk);
    lvl_in = 1'b1; pulse_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_obs !== exp_obs) begin
        miscompares++;
        $display("FAIL single_model i=%0d: got %b want %b", i, dut_obs, exp_obs);
      end
      if (pulse_vld === 1'b1) begin
        vld_cycles++;
        if (first_vld == 0) first_vld = i;
      end
      if (ack_lvl === 1'b1 && first_ack == 0) first_ack = i;
    end
    vectors++;
    if (first_vld != S + 1) begin
      miscompares++;
      $display("FAIL single_latency: got %0d want %0d", first_vld, S + 1);
    end
    vectors++;
    if (vld_cycles != 1) begin
      miscompares++;
      $display("FAIL single_width: got %0d want 1", vld_cycles);
    end
    vectors++;
    if (first_ack != (ACK_EN ? S + 2 : 0)) begin
      miscompares++;
      $display("FAIL single_ack: got %0d want %0d", first_ack, ACK_EN ? S + 2 : 0);
    end
    vectors++;
    if (pend_cnt !== '0) begin
      miscompares++;
      $display("FAIL single_drain: got %0d want 0", pend_cnt);
    end
  endtask

  task automatic test_backpressure();
    int fires = 0;
    do_reset();
    for (int t = 0; t < 5; t++) begin
      lvl_in = ~lvl_in;
      repeat (4) begin
        @(negedge clk);
        vectors++;
        if (dut_obs !== exp_obs) begin
          miscompares++;
          $display("FAIL bp_fill: got %b want %b", dut_obs, exp_obs);
        end
      end
    end
    repeat (S + 2) @(negedge clk);
    vectors++;
    if (pend_cnt !== CW'(5) || pulse_vld !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_count: got cnt=%0d vld=%b want cnt=5 vld=1", pend_cnt, pulse_vld);
    end
    pulse_rdy = 1'b1;
    repeat (8) begin
      if (pulse_vld === 1'b1) fires++;
      @(negedge clk);
      vectors++;
      if (dut_obs !== exp_obs) begin
        miscompares++;
        $display("FAIL bp_drain: got %b want %b", dut_obs, exp_obs);
      end
    end
    vectors++;
    if (fires != 5 || pend_cnt !== '0 || ack_lvl !== ACK_EN) begin
      miscompares++;
      $display("FAIL bp_end: got fires=%0d cnt=%0d ack=%b want 5 0 %b", fires, pend_cnt, ack_lvl, ACK_EN);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int t = 0; t < 17; t++) begin
      lvl_in = ~lvl_in;
      repeat (4) begin
        @(negedge clk);
        vectors++;
        if (dut_obs !== exp_obs) begin
          miscompares++;
          $display("FAIL ovf_fill: got %b want %b", dut_obs, exp_obs);
        end
      end
    end
    repeat (S + 2) @(negedge clk);
    vectors++;
    if (pend_cnt !== CW'(MAXC) || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set: got cnt=%0d ovf=%b want cnt=%0d ovf=1", pend_cnt, ovf, MAXC);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    vectors++;
    if (pend_cnt !== CW'(MAXC) || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear: got cnt=%0d ovf=%b want cnt=%0d ovf=0", pend_cnt, ovf, MAXC);
    end
  endtask

  task automatic test_simultaneous();
    lvl_in = ~lvl_in;
    repeat (S) @(negedge clk);
    pulse_rdy = 1'b1;
    @(negedge clk);
    pulse_rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (dut_obs !== exp_obs) begin
        miscompares++;
        $display("FAIL simul_model: got %b want %b", dut_obs, exp_obs);
      end
    end
    vectors++;
    if (pend_cnt !== CW'(MAXC) || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_hold: got cnt=%0d ovf=%b want cnt=%0d ovf=0", pend_cnt, ovf, MAXC);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    for (int t = 0; t < 3; t++) begin
      lvl_in = ~lvl_in;
      repeat (4) @(negedge clk);
    end
    repeat (S + 2) @(negedge clk);
    vectors++;
    if (pend_cnt !== CW'(3)) begin
      miscompares++;
      $display("FAIL rstmid_pre: got %0d want 3", pend_cnt);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (pend_cnt !== '0 || pulse_vld !== 1'b0 || ack_lvl !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_async: got cnt=%0d vld=%b ack=%b want 0 0 0", pend_cnt, pulse_vld, ack_lvl);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      vectors++;
      if (dut_obs !== exp_obs) begin
        miscompares++;
        $display("FAIL rstmid_model: got %b want %b", dut_obs, exp_obs);
      end
    end
    vectors++;
    if (pend_cnt !== CW'(1)) begin
      miscompares++;
      $display("FAIL rstmid_artefact: got %0d want 1", pend_cnt);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    int rdy_pct = 50;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      vectors++;
      if (dut_obs !== exp_obs) begin
        miscompares++;
        $display("FAIL random c=%0d: got %b want %b", c, dut_obs, exp_obs);
      end
      if (c % 150 == 0) rdy_pct = $urandom_range(0, 100);
      hold++;
      if (hold >= S + 1 && $urandom_range(0, 2) == 0) begin
        lvl_in = ~lvl_in;
        hold = 0;
      end
      pulse_rdy = ($urandom_range(0, 99) < rdy_pct);
      ovf_clr   = ($urandom_range(0, 15) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_simultaneous();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
